// File: rtl/chan_mux_pkg.sv
// Shared encodings and sizing helpers for the N-to-1 channel multiplexer.
package chan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CH_MIN = 2;
    localparam int unsigned CH_MAX = 16;

    // Index width for a channel count; channel counts below two still get one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requester after ptr, wrapping, with ptr itself checked last.
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter int unsigned CH_NUM = 4,
    localparam int unsigned IDX_W = sel_w(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [CH_NUM-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            idx = IDX_W'((32'(ptr) + i) % CH_NUM);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/chan_mux_nto1.sv
// N-to-1 channel multiplexer with one output register stage, fixed or round-robin select.
// Optional 16-bit output beat counter port beat_cnt when CHAN_MUX_CNT_EN is defined.
module chan_mux_nto1
    import chan_mux_pkg::*;
#(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned SEL_W = sel_w(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    input  logic [CH_NUM-1:0]        in_valid,
    output logic [CH_NUM-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
`ifdef CHAN_MUX_CNT_EN
   ,output logic [CNT_W-1:0]         beat_cnt
`endif
);

    if (CH_NUM < CH_MIN || CH_NUM > CH_MAX) begin : g_bad_ch_num
        $error("chan_mux_nto1: CH_NUM must be within 2..16");
    end

    state_e             state;
    logic [SEL_W-1:0]   ptr;
    logic [CH_NUM-1:0]  rr_grant;
    logic [SEL_W-1:0]   rr_idx;
    logic [CH_NUM-1:0]  fix_grant;
    logic [CH_NUM-1:0]  grant;
    logic [SEL_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               rr_sel;
    logic               can_accept;
    logic               in_beat;
    logic               out_beat;

    rr_arbiter #(
        .CH_NUM    (CH_NUM)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Fixed select only grants a valid channel; out-of-range sel matches nothing.
    always_comb begin
        fix_grant = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            fix_grant[k] = in_valid[k] && (sel == SEL_W'(k));
        end
    end

    assign rr_sel    = (mode == MODE_RR);
    assign grant     = rr_sel ? rr_grant : fix_grant;
    assign grant_idx = rr_sel ? rr_idx   : sel;

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            if (grant[k]) begin
                grant_data = grant_data | in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is forced low during reset so no upstream beat completes while the word is discarded.
    assign can_accept = (state == ST_EMPTY) || out_ready;
    assign in_ready   = (can_accept && !rst) ? grant : '0;
    assign in_beat    = |(in_valid & in_ready);
    assign out_valid  = (state == ST_FULL);
    assign out_beat   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= SEL_W'(CH_NUM - 1);
        end else begin
            if (in_beat) begin
                state    <= ST_FULL;
                out_data <= grant_data;
                out_ch   <= grant_idx;
                if (rr_sel) begin
                    ptr <= grant_idx;
                end
            end else if (out_beat) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef CHAN_MUX_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (out_beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
`endif

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_chan_mux_nto1.sv
// Scoreboard bench for chan_mux_nto1: directed scenarios plus randomized traffic.
module tb_chan_mux_nto1;
    import chan_mux_pkg::*;

    localparam int unsigned CH_NUM = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = $clog2(CH_NUM);
    localparam int unsigned N_RAND = 2000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  ch;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [CH_NUM*DATA_W-1:0] in_data;
    logic [CH_NUM-1:0]        in_valid;
    logic [CH_NUM-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEL_W-1:0]         out_ch;

    logic                     u3_mode;
    logic [1:0]               u3_sel;
    logic [23:0]              u3_in_data;
    logic [2:0]               u3_in_valid;
    logic [2:0]               u3_in_ready;
    logic [7:0]               u3_out_data;
    logic                     u3_out_valid;
    logic                     u3_out_ready;
    logic [1:0]               u3_out_ch;
`ifdef CHAN_MUX_CNT_EN
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         u3_beat_cnt;
`endif

    int   n_chk;
    int   n_fail;
    int   m_ptr;
    int   m_occ;
    exp_t q[$];

    chan_mux_nto1 #(.CH_NUM(CH_NUM), .DATA_W(DATA_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef CHAN_MUX_CNT_EN
       ,.beat_cnt  (beat_cnt)
`endif
    );

    chan_mux_nto1 #(.CH_NUM(3), .DATA_W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (u3_mode),
        .sel       (u3_sel),
        .in_data   (u3_in_data),
        .in_valid  (u3_in_valid),
        .in_ready  (u3_in_ready),
        .out_data  (u3_out_data),
        .out_valid (u3_out_valid),
        .out_ready (u3_out_ready),
        .out_ch    (u3_out_ch)
`ifdef CHAN_MUX_CNT_EN
       ,.beat_cnt  (u3_beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: grant by the selection rules, capacity of one word, expected words queued in order.
    task automatic model_cycle();
        int               g;
        logic [CH_NUM-1:0] exp_rdy;
        exp_t             e;
        g = -1;
        if (mode == MODE_RR) begin
            for (int i = 1; i <= int'(CH_NUM); i++) begin
                int c;
                c = (m_ptr + i) % int'(CH_NUM);
                if (g < 0 && in_valid[c[SEL_W-1:0]]) g = c;
            end
        end else if (int'(sel) < int'(CH_NUM) && in_valid[sel]) begin
            g = int'(sel);
        end
        exp_rdy = (g >= 0 && (m_occ == 0 || out_ready)) ? (CH_NUM'(1) << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_occ));
        if (exp_rdy != '0) begin
            e.data = DATA_W'(in_data >> (g * int'(DATA_W)));
            e.ch   = SEL_W'(g);
            q.push_back(e);
            if (mode == MODE_RR) m_ptr = g;
            m_occ = 1;
        end else if (m_occ == 1 && out_ready) begin
            m_occ = 0;
        end
    endtask

    task automatic step(input logic m, input logic [SEL_W-1:0] s, input logic [CH_NUM-1:0] v,
                        input logic [CH_NUM*DATA_W-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle();
        step(MODE_RR, '0, '0, '0, 1'b1);
    endtask

    // Called at a falling edge; reset lands mid-cycle, inputs still asserted.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
`ifdef CHAN_MUX_CNT_EN
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
        in_valid = '0;
        q.delete();
        m_ptr = int'(CH_NUM) - 1;
        m_occ = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got beat ch=%0d data=0x%0h, expected no beat", out_ch, out_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_ch", 32'(out_ch), 32'(e.ch));
                end
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_ptr = int'(CH_NUM) - 1;
        m_occ = 0;
        rst = 1'b1;
        mode = MODE_FIXED;
        sel = '0;
        in_data = '0;
        in_valid = '0;
        out_ready = 1'b0;
        u3_mode = MODE_FIXED;
        u3_sel = '0;
        u3_in_data = '0;
        u3_in_valid = '0;
        u3_out_ready = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = '1;
        u3_in_valid = '1;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_out_ch", 32'(out_ch), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd0);
        chk("init_u3_out_valid", 32'(u3_out_valid), 32'd0);
        in_valid = '0;
        u3_in_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with every channel valid starts at channel 0 and rotates.
        for (int i = 0; i < 6; i++) begin
            step(MODE_RR, '0, '1, 32'h44332211, 1'b1);
            if (i >= 1) chk("rr_seq_ch", 32'(out_ch), 32'((i - 1) % 4));
        end

        // Fixed select of channel 2.
        step(MODE_FIXED, SEL_W'(2), 4'b0100, 32'h00A50000, 1'b1);
        step(MODE_FIXED, SEL_W'(2), 4'b0000, 32'h0, 1'b1);
        chk("fix_out_valid", 32'(out_valid), 32'd1);
        chk("fix_out_data", 32'(out_data), 32'hA5);
        chk("fix_out_ch", 32'(out_ch), 32'd2);

        // Held word survives sel toggling while downstream stalls.
        step(MODE_FIXED, SEL_W'(2), 4'b0100, 32'h003C0000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step(MODE_FIXED, (j == 1) ? SEL_W'(2) : SEL_W'(1), 4'b0110, 32'h003C7700, 1'b0);
            chk("hold_data", 32'(out_data), 32'h3C);
            chk("hold_ch", 32'(out_ch), 32'd2);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        step(MODE_FIXED, SEL_W'(1), 4'b0010, 32'h00007700, 1'b1);
        step(MODE_FIXED, SEL_W'(1), 4'b0000, 32'h0, 1'b1);
        chk("after_hold_data", 32'(out_data), 32'h77);
        chk("after_hold_ch", 32'(out_ch), 32'd1);

        // ptr=1 with channels 1 and 3 requesting: 3 wins, then 1.
        step(MODE_RR, '0, 4'b0010, 32'h0000BB00, 1'b1);
        step(MODE_RR, '0, 4'b1010, 32'hDD00BB00, 1'b1);
        chk("rr_pre_ch", 32'(out_ch), 32'd1);
        step(MODE_RR, '0, 4'b1010, 32'hDD00BB00, 1'b1);
        chk("rr_1010_first", 32'(out_ch), 32'd3);
        step(MODE_RR, '0, 4'b0000, 32'h0, 1'b1);
        chk("rr_1010_second", 32'(out_ch), 32'd1);
        idle();

        // Three-channel instance: out-of-range sel grants nothing, held word still drains.
        u3_mode = MODE_FIXED;
        u3_sel = 2'd0;
        u3_in_valid = 3'b111;
        u3_in_data = 24'h0C0B0A;
        u3_out_ready = 1'b0;
        #1;
        chk("u3_load_ready", 32'(u3_in_ready), 32'b001);
        idle();
        u3_sel = 2'd3;
        #1;
        chk("u3_sel3_ready", 32'(u3_in_ready), 32'd0);
        chk("u3_full_valid", 32'(u3_out_valid), 32'd1);
        chk("u3_full_data", 32'(u3_out_data), 32'h0A);
        chk("u3_full_ch", 32'(u3_out_ch), 32'd0);
        idle();
        u3_out_ready = 1'b1;
        #1;
        chk("u3_drain_ready", 32'(u3_in_ready), 32'd0);
        chk("u3_drain_valid", 32'(u3_out_valid), 32'd1);
        idle();
        #1;
        chk("u3_empty_valid", 32'(u3_out_valid), 32'd0);
        chk("u3_empty_ready", 32'(u3_in_ready), 32'd0);
        u3_in_valid = '0;
        u3_out_ready = 1'b0;

        // Reset while a word is held.
        step(MODE_RR, '0, 4'b0001, 32'h000000EE, 1'b0);
        step(MODE_FIXED, SEL_W'(2), 4'b0100, 32'h00990000, 1'b0);
        chk("pre_rst_data", 32'(out_data), 32'hEE);
        pulse_reset();
        step(MODE_RR, '0, '1, 32'h44332211, 1'b1);
        step(MODE_RR, '0, '0, 32'h0, 1'b1);
        chk("post_rst_ch", 32'(out_ch), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'h11);

        for (int n = 0; n < int'(N_RAND); n++) begin
            step(logic'($urandom_range(0, 1)), SEL_W'($urandom), CH_NUM'($urandom),
                 32'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (3) idle();
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);

`ifdef CHAN_MUX_CNT_EN
        pulse_reset();
        for (int i = 1; i <= 65537; i++) begin
            step(MODE_RR, '0, '1, 32'($urandom), 1'b1);
            if (i == 10) chk("beat_cnt_mid", 32'(beat_cnt), 32'd8);
        end
        idle();
        chk("beat_cnt_wrap", 32'(beat_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_mux_nto1.md
CHAN_MUX_NTO1 -- requirements
Module: chan_mux_nto1

Interface
REQ-001 Parameter CH_NUM, default 4, number of input channels; SHALL be 2..16.
REQ-002 Parameter DATA_W, default 8, bits per channel data word.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-006 sel  input  SEL_W=$clog2(CH_NUM)  channel index, used in fixed mode.
REQ-007 in_data  input  CH_NUM*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 in_valid  input  CH_NUM  per-channel valid.
REQ-009 in_ready  output  CH_NUM  per-channel ready, combinational, one-hot or zero.
REQ-010 out_data  output  DATA_W  registered output word.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  downstream ready.
REQ-013 out_ch  output  SEL_W  source channel of out_data.

Function
REQ-014 Beat transfer: input beat on channel k when in_valid[k] and in_ready[k]; output beat when out_valid and out_ready.
REQ-015 One output register stage; latency input beat -> out_valid SHALL be exactly 1 cycle.
REQ-016 FSM states EMPTY and FULL; EMPTY->FULL on input beat; FULL->EMPTY on output beat without input beat; FULL->FULL on output and input beat in same cycle.
REQ-017 Capacity SHALL be true: in_ready[grant] = (state==EMPTY) or out_ready; all other in_ready bits 0.
REQ-018 out_data, out_ch, out_valid SHALL hold stable while out_valid and !out_ready.
REQ-019 Fixed mode: grant = sel, sampled combinationally; a change of sel SHALL never corrupt a held output word.
REQ-020 Fixed mode, sel >= CH_NUM: no grant, all in_ready 0, output drains normally.
REQ-021 Round-robin: pointer ptr; grant = first channel with in_valid set searching ptr+1, ptr+2, ... wrapping modulo CH_NUM, ptr itself last.
REQ-022 Round-robin: ptr SHALL update to the granted channel only on an input beat; no beat, no update.
REQ-023 mode change SHALL take effect on the next cycle's grant; ptr retained across mode changes.
REQ-024 No channel valid: no grant, no state change.

Reset
REQ-025 On rst: state EMPTY, out_valid 0, out_data 0, out_ch 0, ptr CH_NUM-1 (so channel 0 wins first).
REQ-026 rst asserted mid-transfer SHALL discard the held word immediately; no beat completes in that cycle.
REQ-027 Reset release SHALL be synchronised by the top level; block uses rst directly.

Configuration
REQ-028 Macro CHAN_MUX_CNT_EN defined: extra output beat_cnt, 16 bits, counts output beats, wraps 0xFFFF->0, reset 0.
REQ-029 Macro undefined: port beat_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package chan_mux_pkg: mode encodings MODE_FIXED/MODE_RR, state encodings ST_EMPTY/ST_FULL, CNT_W=16.
REQ-031 Sub-module rr_arbiter (parameter CH_NUM; inputs req, ptr; output grant one-hot, grant_idx) holds the round-robin search.

Verification
REQ-032 Fixed, sel=2, in_valid=4'b0100, data 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-033 Fixed, out_ready=0 for 3 cycles with held word 0x3C, sel toggled 2->1 -> out_data stays 0x3C, in_ready=0 until drain.
REQ-034 RR, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-035 RR, in_valid=4'b1010, ptr=1 -> channel 3 granted, then 1.
REQ-036 CH_NUM=3, fixed, sel=3 -> in_ready=0, out_valid falls after held word drains.
REQ-037 rst pulsed while FULL -> out_valid 0 same cycle; with CHAN_MUX_CNT_EN, beat_cnt 0; 65536 beats -> beat_cnt 0.
